// File: rtl/main_memory_write_controller_pkg.sv
// main_memory_write_controller_pkg: shared state encodings, defaults and lane index sizing
package main_memory_write_controller_pkg;
  localparam int ADC_MAX_DATA_SIZE_DEF = 16;
  localparam int BRAM_WORD_NUM_DEF     = 8;
  localparam int BRAM_ADDR_WIDTH_DEF   = 10;
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;
  function automatic int lane_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/main_memory_write_controller_if.sv
// main_memory_write_controller_if: sample input, capture control, BRAM write port and status
interface main_memory_write_controller_if
  import main_memory_write_controller_pkg::*;
#(
  parameter int ADC_MAX_DATA_SIZE = ADC_MAX_DATA_SIZE_DEF,
  parameter int BRAM_WORD_NUM     = BRAM_WORD_NUM_DEF,
  parameter int BRAM_ADDR_WIDTH   = BRAM_ADDR_WIDTH_DEF
);
  logic [ADC_MAX_DATA_SIZE-1:0]               data;
  logic                                       data_vld;
  logic                                       start;
  logic                                       abort;
  logic                                       trig_en;
  logic                                       trig;
  logic [BRAM_ADDR_WIDTH-1:0]                 last_addr;
  logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] bram_data;
  logic [BRAM_ADDR_WIDTH-1:0]                 bram_addr;
  logic                                       bram_we;
  logic                                       busy;
  logic                                       done;
  logic                                       overflow;
  modport master (
    output data, data_vld, start, abort, trig_en, trig, last_addr,
    input  bram_data, bram_addr, bram_we, busy, done, overflow
  );
  modport slave (
    input  data, data_vld, start, abort, trig_en, trig, last_addr,
    output bram_data, bram_addr, bram_we, busy, done, overflow
  );
endinterface

// File: rtl/main_memory_sample_packer.sv
// main_memory_sample_packer: packs accepted samples into lanes of one wide word, lane 0 first
module main_memory_sample_packer
  import main_memory_write_controller_pkg::*;
#(
  parameter int ADC_MAX_DATA_SIZE = ADC_MAX_DATA_SIZE_DEF,
  parameter int BRAM_WORD_NUM     = BRAM_WORD_NUM_DEF
) (
  input  logic                                       i_write_ctrl_clk,
  input  logic                                       i_write_ctrl_rst,
  input  logic                                       clr,
  input  logic                                       vld,
  input  logic [ADC_MAX_DATA_SIZE-1:0]               data,
  output logic [ADC_MAX_DATA_SIZE*BRAM_WORD_NUM-1:0] word,
  output logic                                       full
);
  localparam int LW = lane_idx_width(BRAM_WORD_NUM);
  logic [LW-1:0] idx;
  assign full = vld & (idx == LW'(BRAM_WORD_NUM - 1));
  // lane write and index advance; unfilled lanes keep stale data
  always_ff @(posedge i_write_ctrl_clk or posedge i_write_ctrl_rst)
    if (i_write_ctrl_rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (vld) begin
      word[idx*ADC_MAX_DATA_SIZE +: ADC_MAX_DATA_SIZE] <= data;
      idx <= full ? '0 : idx + 1'b1;
    end
endmodule

// File: rtl/main_memory_write_controller.sv
// main_memory_write_controller: start/trigger/stop capture of ADC samples into auto-addressed BRAM words
module main_memory_write_controller
  import main_memory_write_controller_pkg::*;
#(
  parameter int ADC_MAX_DATA_SIZE = ADC_MAX_DATA_SIZE_DEF,
  parameter int BRAM_WORD_NUM     = BRAM_WORD_NUM_DEF,
  parameter int BRAM_ADDR_WIDTH   = BRAM_ADDR_WIDTH_DEF
) (
  input logic                          i_write_ctrl_clk,
  input logic                          i_write_ctrl_rst,
  main_memory_write_controller_if.slave bus
);
  state_t state, state_nx;
  logic trig_d, trig_edge, start_ok, accept, word_full, last_write;
  logic [BRAM_ADDR_WIDTH-1:0] last_q, addr;
  assign trig_edge  = bus.trig & ~trig_d;
  assign start_ok   = bus.start & ~bus.abort & (state == ST_IDLE || state == ST_DONE);
  assign accept     = bus.data_vld & ~bus.abort & (state == ST_CAPTURE || (state == ST_ARMED && trig_edge));
  assign last_write = word_full & (addr == last_q);
  assign bus.busy   = (state == ST_ARMED) || (state == ST_CAPTURE);
  main_memory_sample_packer #(
    .ADC_MAX_DATA_SIZE(ADC_MAX_DATA_SIZE),
    .BRAM_WORD_NUM    (BRAM_WORD_NUM)
  ) u_packer (
    .i_write_ctrl_clk(i_write_ctrl_clk),
    .i_write_ctrl_rst(i_write_ctrl_rst),
    .clr             (start_ok | bus.abort),
    .vld             (accept),
    .data            (bus.data),
    .word            (bus.bram_data),
    .full            (word_full)
  );
  // state register
  always_ff @(posedge i_write_ctrl_clk or posedge i_write_ctrl_rst)
    if (i_write_ctrl_rst) state <= ST_IDLE;
    else                  state <= state_nx;
  // next state: abort beats start, the final write beats the trigger that starts a one-lane word
  always_comb begin
    state_nx = state;
    state_nx = bus.abort ? ST_IDLE :
               start_ok ? (bus.trig_en ? ST_ARMED : ST_CAPTURE) :
               last_write ? ST_DONE :
               (state == ST_ARMED && trig_edge) ? ST_CAPTURE : state;
  end
  // trigger history, write strobe, address counter (no wrap past last_addr) and sticky status
  always_ff @(posedge i_write_ctrl_clk or posedge i_write_ctrl_rst)
    if (i_write_ctrl_rst) begin
      trig_d        <= 1'b0;
      last_q        <= '0;
      addr          <= '0;
      bus.bram_addr <= '0;
      bus.bram_we   <= 1'b0;
      bus.done      <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      trig_d      <= bus.trig;
      bus.bram_we <= word_full;
      if (word_full) begin
        bus.bram_addr <= addr;
        addr          <= last_write ? addr : addr + 1'b1;
      end
      if (last_write) bus.done <= 1'b1;
      if (state == ST_DONE && bus.data_vld && !start_ok) bus.overflow <= 1'b1;
      if (start_ok) begin
        last_q       <= bus.last_addr;
        addr         <= '0;
        bus.done     <= 1'b0;
        bus.overflow <= 1'b0;
      end
    end
endmodule
